fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the pipelined MIPS core: owns the PC, drives the instruction-memory address, and produces the IF/ID pipeline register. It replaces the fixed `pc`/`ifid_*` logic in the top level. It adds a memory-ready handshake, hazard stall, pipeline flush on redirect, and an optional direct-mapped branch target buffer (BTB) for next-PC prediction.

---
 rtl/fetch_unit.sv | 154 +++++++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage owning the PC, the fetch address and the IF/ID register.
// Define FETCH_BTB_EN to compile in the direct-mapped BTB next-PC predictor.
module fetch_unit #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter logic [XLEN-1:0] INST_NOP  = 32'h0000_0000,
   parameter int unsigned     BTB_DEPTH = 16
) (
   input  logic            clk,
   input  logic            reset,
   output logic [XLEN-1:0] inst_addr,
   input  logic [XLEN-1:0] inst_mem,
   input  logic            MIO_ready,
   input  logic            stall,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            bt_update,
   input  logic [XLEN-1:0] bt_pc,
   input  logic [XLEN-1:0] bt_target,
   input  logic            bt_taken,
   output logic [XLEN-1:0] ifid_ir,
   output logic [XLEN-1:0] ifid_pc,
   output logic            ifid_valid,
   output logic            ifid_pred_taken
);

   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] ir_q, ir_d;
   logic [XLEN-1:0] ifpc_q, ifpc_d;
   logic            valid_q, valid_d;
   logic            pred_q, pred_d;
   logic [XLEN-1:0] pc_plus4;
   logic            pred_taken;
   logic [XLEN-1:0] pred_target;

   assign pc_plus4 = pc_q + XLEN'(4);

`ifdef FETCH_BTB_EN
   localparam int unsigned IW = $clog2(BTB_DEPTH);
   localparam int unsigned TW = XLEN - IW - 2;

   logic [BTB_DEPTH-1:0] btb_v_q;
   logic [TW-1:0]        btb_tag_q [BTB_DEPTH];
   logic [1:0]           btb_cnt_q [BTB_DEPTH];
   logic [XLEN-1:0]      btb_tgt_q [BTB_DEPTH];

   logic [IW-1:0] lk_idx;
   logic [TW-1:0] lk_tag;
   logic [IW-1:0] up_idx;
   logic [TW-1:0] up_tag;
   logic          up_hit;
   logic          unused_bt_lsb;

   assign lk_idx        = pc_q[IW+1:2];
   assign lk_tag        = pc_q[XLEN-1:IW+2];
   assign up_idx        = bt_pc[IW+1:2];
   assign up_tag        = bt_pc[XLEN-1:IW+2];
   assign unused_bt_lsb = ^bt_pc[1:0];

   // Registered storage: a same-cycle update is only seen by the next lookup.
   assign pred_taken  = btb_v_q[lk_idx]
                      && (btb_tag_q[lk_idx] == lk_tag)
                      && btb_cnt_q[lk_idx][1];
   assign pred_target = btb_tgt_q[lk_idx];
   assign up_hit      = btb_v_q[up_idx] && (btb_tag_q[up_idx] == up_tag);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btb_v_q <= '0;
      end else if (bt_update && bt_taken) begin
         btb_v_q[up_idx] <= 1'b1;
      end
   end

   // Tags, counters and targets need no reset: valid gates every use.
   always_ff @(posedge clk) begin
      if (bt_update) begin
         if (up_hit) begin
            if (bt_taken) begin
               if (btb_cnt_q[up_idx] != 2'b11) begin
                  btb_cnt_q[up_idx] <= btb_cnt_q[up_idx] + 2'd1;
               end
               btb_tgt_q[up_idx] <= bt_target;
            end else if (btb_cnt_q[up_idx] != 2'b00) begin
               btb_cnt_q[up_idx] <= btb_cnt_q[up_idx] - 2'd1;
            end
         end else if (bt_taken) begin
            btb_tag_q[up_idx] <= up_tag;
            btb_cnt_q[up_idx] <= 2'b10;
            btb_tgt_q[up_idx] <= bt_target;
         end
      end
   end
`else
   localparam int unsigned unused_btb_depth = BTB_DEPTH;

   logic unused_bt;

   assign unused_bt   = ^{bt_update, bt_pc, bt_target, bt_taken};
   assign pred_taken  = 1'b0;
   assign pred_target = pc_plus4;
`endif

   always_comb begin
      pc_d = pc_plus4;
      if (redirect) begin
         pc_d = redirect_pc;
      end else if (stall || !MIO_ready) begin
         pc_d = pc_q;
      end else if (pred_taken) begin
         pc_d = pred_target;
      end
   end

   always_comb begin
      ir_d    = ir_q;
      ifpc_d  = ifpc_q;
      valid_d = valid_q;
      pred_d  = pred_q;
      if (redirect || (!stall && !MIO_ready)) begin
         ir_d    = INST_NOP;
         valid_d = 1'b0;
         pred_d  = 1'b0;
      end else if (!stall) begin
         ir_d    = inst_mem;
         ifpc_d  = pc_plus4;
         valid_d = 1'b1;
         pred_d  = pred_taken;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         ir_q    <= INST_NOP;
         ifpc_q  <= '0;
         valid_q <= 1'b0;
         pred_q  <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ifpc_q  <= ifpc_d;
         valid_q <= valid_d;
         pred_q  <= pred_d;
      end
   end

   assign inst_addr       = pc_q;
   assign ifid_ir         = ir_q;
   assign ifid_pc         = ifpc_q;
   assign ifid_valid      = valid_q;
   assign ifid_pred_taken = pred_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit against a spec-level model.
// Works for both the default build and FETCH_BTB_EN builds.
module tb_fetch_unit;

   localparam int unsigned D = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] inst_addr;
   logic [31:0] inst_mem;
   logic        MIO_ready = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        bt_update = 1'b0;
   logic [31:0] bt_pc = '0;
   logic [31:0] bt_target = '0;
   logic        bt_taken = 1'b0;
   logic [31:0] ifid_ir;
   logic [31:0] ifid_pc;
   logic        ifid_valid;
   logic        ifid_pred_taken;

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .INST_NOP(32'h0), .BTB_DEPTH(D)) dut (
      .clk(clk), .reset(reset), .inst_addr(inst_addr), .inst_mem(inst_mem),
      .MIO_ready(MIO_ready), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .bt_update(bt_update), .bt_pc(bt_pc),
      .bt_target(bt_target), .bt_taken(bt_taken), .ifid_ir(ifid_ir),
      .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
      .ifid_pred_taken(ifid_pred_taken)
   );

   // Memory returns the address as the instruction word.
   assign inst_mem = inst_addr;

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] ir;
      logic [31:0] pc;
      logic        valid;
      logic        pred;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   logic [31:0] m_pc, m_ir, m_ifpc;
   logic        m_valid, m_pred;
   bit          bv[D];
   logic [31:0] btag[D];
   logic [31:0] btgt[D];
   int          bcnt[D];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_ir = 32'h0; m_ifpc = 32'h0;
      m_valid = 1'b0; m_pred = 1'b0;
      for (int i = 0; i < D; i++) bv[i] = 1'b0;
   endtask

   function automatic logic [31:0] idx_of(logic [31:0] a);
      return (a / 4) % D;
   endfunction

   function automatic logic [31:0] tag_of(logic [31:0] a);
      return a / (4 * D);
   endfunction

   function automatic bit predict(logic [31:0] a);
`ifdef FETCH_BTB_EN
      logic [31:0] i = idx_of(a);
      return bv[i] && (btag[i] == tag_of(a)) && (bcnt[i] >= 2);
`else
      return (a != a);
`endif
   endfunction

   task automatic step(bit rd, logic [31:0] rpc, bit st, bit rdy,
                       bit up, logic [31:0] bpc, logic [31:0] btg, bit btk);
      bit          pt;
      logic [31:0] ptgt, npc;
      exp_t        e;
      redirect = rd; redirect_pc = rpc; stall = st; MIO_ready = rdy;
      bt_update = up; bt_pc = bpc; bt_target = btg; bt_taken = btk;
      pt   = predict(m_pc);
      ptgt = btgt[idx_of(m_pc)];
      if (rd) npc = rpc;
      else if (st || !rdy) npc = m_pc;
      else if (pt) npc = ptgt;
      else npc = m_pc + 32'd4;
      if (rd || (!st && !rdy)) begin
         m_ir = 32'h0; m_valid = 1'b0; m_pred = 1'b0;
      end else if (!st) begin
         m_ir = m_pc; m_ifpc = m_pc + 32'd4; m_valid = 1'b1; m_pred = pt;
      end
      m_pc = npc;
`ifdef FETCH_BTB_EN
      if (up) begin
         logic [31:0] i = idx_of(bpc);
         if (bv[i] && btag[i] == tag_of(bpc)) begin
            if (btk) begin
               bcnt[i] = (bcnt[i] < 3) ? bcnt[i] + 1 : 3;
               btgt[i] = btg;
            end else begin
               bcnt[i] = (bcnt[i] > 0) ? bcnt[i] - 1 : 0;
            end
         end else if (btk) begin
            bv[i] = 1'b1; btag[i] = tag_of(bpc); bcnt[i] = 2; btgt[i] = btg;
         end
      end
`endif
      e.addr = m_pc; e.ir = m_ir; e.pc = m_ifpc;
      e.valid = m_valid; e.pred = m_pred;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic go(int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
   endtask

   task automatic check_reset_outputs();
      chk("rst_inst_addr", inst_addr, 32'h0);
      chk("rst_ifid_ir", ifid_ir, 32'h0);
      chk("rst_ifid_pc", ifid_pc, 32'h0);
      chk("rst_ifid_valid", {31'b0, ifid_valid}, 32'h0);
      chk("rst_ifid_pred", {31'b0, ifid_pred_taken}, 32'h0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("inst_addr", inst_addr, e.addr);
            chk("ifid_ir", ifid_ir, e.ir);
            chk("ifid_pc", ifid_pc, e.pc);
            chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
            chk("ifid_pred_taken", {31'b0, ifid_pred_taken}, {31'b0, e.pred});
         end
      end
   end

   initial begin : stim
      bit          rd, st, rdy, up, btk;
      logic [31:0] rpc, bpc, btg;
      #2 reset = 1'b1;
      #1 check_reset_outputs();
      model_reset();
      @(negedge clk);
      reset = 1'b0;

      go(4);
      step(0, 0, 1, 1, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0, 0, 0);
      go(2);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
      go(1);
      step(1, 32'h400, 1, 1, 0, 0, 0, 0);
      go(2);

      step(1, 32'h20, 0, 1, 1, 32'h20, 32'h100, 1);
      go(3);
      step(0, 0, 0, 1, 1, 32'h20, 32'h100, 1);
      step(0, 0, 0, 1, 1, 32'h20, 32'h100, 0);
      step(0, 0, 0, 1, 1, 32'h20, 32'h100, 0);
      step(1, 32'h20, 0, 1, 0, 0, 0, 0);
      go(3);
      step(1, 32'h30, 0, 1, 1, 32'h30, 32'h200, 0);
      go(3);
      step(1, 32'hFFFF_FFFC, 0, 1, 0, 0, 0, 0);
      go(3);

      for (int n = 0; n < 2000; n++) begin
         if (n == 900) begin
            bt_update = 1'b0;
            reset = 1'b1;
            #1 check_reset_outputs();
            model_reset();
            @(negedge clk);
            reset = 1'b0;
         end
         rd  = ($urandom_range(0, 7) == 0);
         rpc = 32'($urandom_range(0, 63)) << 2;
         st  = ($urandom_range(0, 5) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         up  = ($urandom_range(0, 2) == 0);
         bpc = ($urandom_range(0, 1) == 0) ? m_pc : (32'($urandom_range(0, 63)) << 2);
         btg = 32'($urandom_range(0, 63)) << 2;
         btk = ($urandom_range(0, 2) != 0);
         step(rd, rpc, st, rdy, up, bpc, btg, btk);
      end

      repeat (2) @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
